// File: rtl/xrv1_dmem_tcm_resp.sv
// xrv1_dmem_tcm_resp: TCM-side dmem responder (byte-enable RAM, range check, wait states, error counter)
module xrv1_dmem_tcm_resp #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmem_req_vld_i,
  output logic        dmem_req_rdy_o,
  input  logic [31:0] dmem_req_addr_i,
  input  logic        dmem_req_w_en_i,
  input  logic [3:0]  dmem_req_w_be_i,
  input  logic [31:0] dmem_req_w_data_i,
  output logic        dmem_resp_vld_o,
  output logic        dmem_resp_err_o,
  output logic [31:0] dmem_resp_r_data_o,
  output logic [15:0] stat_err_cnt_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] RELOAD = 3'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  state_t state;
  logic [31:0] mem [DEPTH_WORDS];
  logic [29:0] off;
  logic [31:0] rd_q;
  logic [2:0] cnt;
  logic [15:0] err_cnt;
  logic [AW-1:0] idx;
  logic rdy_q, vld_q, err_q, rd_ok_q, accept, in_range, unused;
  assign unused = ^dmem_req_addr_i[1:0];
  assign off = dmem_req_addr_i[31:2] - BASE_ADDR[31:2];
  assign in_range = ~|off[29:AW];
  assign idx = off[AW-1:0];
  assign accept = dmem_req_vld_i && rdy_q;
  assign dmem_req_rdy_o = rdy_q;
  assign dmem_resp_vld_o = vld_q;
  assign dmem_resp_err_o = vld_q && err_q;
  assign dmem_resp_r_data_o = vld_q && rd_ok_q ? rd_q : '0;
  assign stat_err_cnt_o = err_cnt;
  always_ff @(posedge clk_i) begin
    if (accept && dmem_req_w_en_i && in_range)
      for (int i = 0; i < 4; i++)
        if (dmem_req_w_be_i[i]) mem[idx][8*i +: 8] <= dmem_req_w_data_i[8*i +: 8];
    if (accept) rd_q <= mem[idx];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
      cnt <= '0;
      err_q <= 1'b0;
      rd_ok_q <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (accept) begin
        err_q <= !in_range;
        rd_ok_q <= !dmem_req_w_en_i && in_range;
      end
      if (vld_q && err_q && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      if (WAIT_STATES == 0) begin
        rdy_q <= 1'b1;
        vld_q <= accept;
      end else begin
        vld_q <= 1'b0;
        case (state)
          ST_WAIT: begin
            if (cnt == '0) begin
              state <= ST_RESP;
              vld_q <= 1'b1;
              rdy_q <= 1'b1;
            end else cnt <= cnt - 1'b1;
          end
          default: begin
            state <= accept ? ST_WAIT : ST_IDLE;
            rdy_q <= !accept;
            cnt <= RELOAD;
          end
        endcase
      end
    end
  end
endmodule
